// File: rtl/sys_mac_pe.sv
// Weight-stationary MAC processing element: held weight, per-tile accumulation
// over k_len beats, double-buffered result with valid/ready drain.
module sys_mac_pe #(
    parameter int W     = 8,
    parameter int ACC_W = 24,
    parameter int NCH   = 3,
    parameter int SAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 w_load,
    input  logic [W-1:0]         w_in,
    output logic [W-1:0]         w_q,
    input  logic [NCH*W-1:0]     a_in,
    input  logic [NCH-1:0]       a_valid,
    output logic [NCH*W-1:0]     a_out,
    output logic [NCH-1:0]       a_valid_out,
    input  logic [CNT_W-1:0]     k_len,
    output logic [ACC_W-1:0]     res_data,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 sat_hit
);

    localparam int SW = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         k_len_q, k_len_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]         res_data_q, res_data_d;
    logic                     res_valid_q, res_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     sat_hit_q, sat_hit_d;
    logic [W-1:0]             w_d;
    logic [NCH*W-1:0]         a_out_q;
    logic [NCH-1:0]           a_valid_out_q;

    logic                     beat_s;
    logic signed [W-1:0]      a_sel_s;
    logic signed [2*W-1:0]    prod_s;
    logic signed [SW-1:0]     sum_s;
    logic signed [ACC_W-1:0]  res_s;
    logic                     sat_s;
    logic [CNT_W-1:0]         k_eff_s;
    logic [CNT_W:0]           cnt_inc_s;
    logic                     complete_s;

    // Lowest-index valid channel wins; products are summed one bit wider to catch overflow.
    always_comb begin
        beat_s  = |a_valid;
        a_sel_s = {W{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            a_sel_s = a_valid[i] ? $signed(a_in[i*W +: W]) : a_sel_s;
        end
        prod_s = a_sel_s * $signed(w_q);
        sum_s  = SW'(acc_q) + SW'(prod_s);
        if ((SAT != 0) && (sum_s[ACC_W] != sum_s[ACC_W-1])) begin
            sat_s = 1'b1;
            res_s = sum_s[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sat_s = 1'b0;
            res_s = sum_s[ACC_W-1:0];
        end
        k_eff_s   = (k_len == {CNT_W{1'b0}}) ? CNT_W'(1'b1) : k_len;
        cnt_inc_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    end

    // Tile sequencing, completion and result drain.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_len_d     = k_len_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;
        sat_hit_d   = sat_hit_q;
        complete_s  = 1'b0;
        w_d         = w_load ? w_in : w_q;

        if (clear) begin
            state_d   = IDLE;
            cnt_d     = {CNT_W{1'b0}};
            acc_d     = {ACC_W{1'b0}};
            overrun_d = 1'b0;
            sat_hit_d = 1'b0;
        end else if (beat_s) begin
            sat_hit_d = sat_hit_q | sat_s;
            case (state_q)
                IDLE: begin
                    k_len_d = k_eff_s;
                    if (k_eff_s == CNT_W'(1'b1)) begin
                        complete_s = 1'b1;
                    end else begin
                        state_d = ACC;
                        cnt_d   = CNT_W'(1'b1);
                        acc_d   = res_s;
                    end
                end
                ACC: begin
                    if (cnt_inc_s == {1'b0, k_len_q}) begin
                        complete_s = 1'b1;
                        state_d    = IDLE;
                        cnt_d      = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_inc_s[CNT_W-1:0];
                        acc_d = res_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    acc_d   = {ACC_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // A completion lands in the output buffer even if the old result was never taken.
        if (complete_s) begin
            acc_d       = {ACC_W{1'b0}};
            res_data_d  = res_s;
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ready) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // State and output registers; pass-through ignores clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            k_len_q       <= {CNT_W{1'b0}};
            acc_q         <= {ACC_W{1'b0}};
            res_data_q    <= {ACC_W{1'b0}};
            res_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            sat_hit_q     <= 1'b0;
            w_q           <= {W{1'b0}};
            a_out_q       <= {(NCH*W){1'b0}};
            a_valid_out_q <= {NCH{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_len_q       <= k_len_d;
            acc_q         <= acc_d;
            res_data_q    <= res_data_d;
            res_valid_q   <= res_valid_d;
            overrun_q     <= overrun_d;
            sat_hit_q     <= sat_hit_d;
            w_q           <= w_d;
            a_out_q       <= a_in;
            a_valid_out_q <= a_valid;
        end
    end

    assign a_out       = a_out_q;
    assign a_valid_out = a_valid_out_q;
    assign res_data    = res_data_q;
    assign res_valid   = res_valid_q;
    assign overrun     = overrun_q;
    assign sat_hit     = sat_hit_q;
    assign busy        = (state_q == ACC);

endmodule

// File: tb/tb_sys_mac_pe.sv
// Scoreboard bench for sys_mac_pe: a 24-bit saturating instance plus a 16-bit
// saturating/wrapping pair driven together.
module tb_sys_mac_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear, w_load, res_ready;
    logic [7:0]  w_in, k_len;
    logic [23:0] a_in;
    logic [2:0]  a_valid;
    logic [7:0]  w_q;
    logic [23:0] a_out, res_data;
    logic [2:0]  a_valid_out;
    logic        res_valid, busy, overrun, sat_hit;

    logic        p_clear, p_w_load, p_res_ready;
    logic [7:0]  p_w_in, p_k_len;
    logic [23:0] p_a_in;
    logic [2:0]  p_a_valid;
    logic [7:0]  ps_w_q, pw_w_q;
    logic [23:0] ps_a_out, pw_a_out;
    logic [2:0]  ps_a_valid_out, pw_a_valid_out;
    logic [15:0] ps_res_data, pw_res_data;
    logic        ps_res_valid, ps_busy, ps_overrun, ps_sat_hit;
    logic        pw_res_valid, pw_busy, pw_overrun, pw_sat_hit;

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];
    logic [15:0] exps_q[$];
    logic [15:0] expw_q[$];

    always #5 clk = ~clk;

    sys_mac_pe #(.W(8), .ACC_W(24), .NCH(3), .SAT(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .w_load(w_load), .w_in(w_in), .w_q(w_q),
        .a_in(a_in), .a_valid(a_valid), .a_out(a_out), .a_valid_out(a_valid_out),
        .k_len(k_len), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .overrun(overrun), .sat_hit(sat_hit)
    );

    sys_mac_pe #(.W(8), .ACC_W(16), .NCH(3), .SAT(1), .CNT_W(8)) dut_s16 (
        .clk(clk), .rst(rst), .clear(p_clear), .w_load(p_w_load), .w_in(p_w_in), .w_q(ps_w_q),
        .a_in(p_a_in), .a_valid(p_a_valid), .a_out(ps_a_out), .a_valid_out(ps_a_valid_out),
        .k_len(p_k_len), .res_data(ps_res_data), .res_valid(ps_res_valid), .res_ready(p_res_ready),
        .busy(ps_busy), .overrun(ps_overrun), .sat_hit(ps_sat_hit)
    );

    sys_mac_pe #(.W(8), .ACC_W(16), .NCH(3), .SAT(0), .CNT_W(8)) dut_w16 (
        .clk(clk), .rst(rst), .clear(p_clear), .w_load(p_w_load), .w_in(p_w_in), .w_q(pw_w_q),
        .a_in(p_a_in), .a_valid(p_a_valid), .a_out(pw_a_out), .a_valid_out(pw_a_valid_out),
        .k_len(p_k_len), .res_data(pw_res_data), .res_valid(pw_res_valid), .res_ready(p_res_ready),
        .busy(pw_busy), .overrun(pw_overrun), .sat_hit(pw_sat_hit)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitors: compare every accepted result against the queue head.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL main_res: unexpected result %0d", $signed(res_data));
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (res_data !== e) begin
                    failures++;
                    $display("FAIL main_res: got %0d expected %0d", $signed(res_data), $signed(e));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ps_res_valid && p_res_ready) begin
            checks++;
            if (exps_q.size() == 0) begin
                failures++;
                $display("FAIL sat16_res: unexpected result %0d", $signed(ps_res_data));
            end else begin
                logic [15:0] e;
                e = exps_q.pop_front();
                if (ps_res_data !== e) begin
                    failures++;
                    $display("FAIL sat16_res: got %0d expected %0d", $signed(ps_res_data), $signed(e));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && pw_res_valid && p_res_ready) begin
            checks++;
            if (expw_q.size() == 0) begin
                failures++;
                $display("FAIL wrap16_res: unexpected result %0d", $signed(pw_res_data));
            end else begin
                logic [15:0] e;
                e = expw_q.pop_front();
                if (pw_res_data !== e) begin
                    failures++;
                    $display("FAIL wrap16_res: got %0d expected %0d", $signed(pw_res_data), $signed(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] v, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
        a_valid = v;
        a_in    = {x2, x1, x0};
        step();
        a_valid = 3'b000;
    endtask

    task automatic load_w(input logic [7:0] w);
        w_load = 1'b1;
        w_in   = w;
        step();
        w_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        rst = 1'b1; clear = 1'b0; w_load = 1'b0; res_ready = 1'b0;
        w_in = 8'd0; k_len = 8'd0; a_in = 24'd0; a_valid = 3'b000;
        p_clear = 1'b0; p_w_load = 1'b0; p_res_ready = 1'b0;
        p_w_in = 8'd0; p_k_len = 8'd0; p_a_in = 24'd0; p_a_valid = 3'b000;
        step();
        step();
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_res_data", {8'd0, res_data}, 32'd0);
        chk("rst_flags", {29'd0, busy, overrun, sat_hit}, 32'd0);
        rst = 1'b0;

        // Basic dot product: w=3, 1..4 -> 30
        load_w(8'd3);
        chk("w_q_load", {24'd0, w_q}, 32'd3);
        k_len = 8'd4;
        res_ready = 1'b1;
        exp_q.push_back(24'd30);
        busy_cnt = 0;
        for (int i = 1; i <= 4; i++) begin
            beat(3'b001, 8'(i), 8'd0, 8'd0);
            busy_cnt += int'(busy);
        end
        chk("dot_busy_cycles", busy_cnt, 32'd3);
        chk("dot_valid_latency", {31'd0, res_valid}, 32'd1);
        step();
        chk("dot_valid_drop", {31'd0, res_valid}, 32'd0);

        // Channel priority: 5*2 + (-4)*2 = 2
        load_w(8'd2);
        k_len = 8'd2;
        exp_q.push_back(24'd2);
        beat(3'b110, 8'h11, 8'd5, 8'd7);
        chk("pass_a_out", {8'd0, a_out}, {8'd0, 8'd7, 8'd5, 8'h11});
        chk("pass_valid_out", {29'd0, a_valid_out}, 32'd6);
        beat(3'b101, 8'hFC, 8'h00, 8'd9);
        chk("pass_a_out2", {8'd0, a_out}, {8'd0, 8'd9, 8'h00, 8'hFC});
        chk("pass_valid_out2", {29'd0, a_valid_out}, 32'd5);
        step();
        chk("main_no_sat", {31'd0, sat_hit}, 32'd0);

        // Saturation vs wrap at 16 bits: 3 x 127*127
        p_w_load = 1'b1; p_w_in = 8'd127;
        step();
        p_w_load = 1'b0;
        p_k_len = 8'd3;
        p_res_ready = 1'b1;
        exps_q.push_back(16'd32767);
        expw_q.push_back(16'(-17149));
        for (int i = 0; i < 3; i++) begin
            p_a_valid = 3'b001;
            p_a_in = {8'd0, 8'd0, 8'd127};
            step();
        end
        p_a_valid = 3'b000;
        chk("sat16_sat_hit", {31'd0, ps_sat_hit}, 32'd1);
        chk("wrap16_sat_hit", {31'd0, pw_sat_hit}, 32'd0);
        step();

        // Backpressure and overrun
        load_w(8'd1);
        k_len = 8'd1;
        res_ready = 1'b0;
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        chk("bp_no_overrun", {31'd0, overrun}, 32'd0);
        exp_q.push_back(24'd2);
        beat(3'b001, 8'd2, 8'd0, 8'd0);
        chk("bp_overrun", {31'd0, overrun}, 32'd1);
        chk("bp_data", {8'd0, res_data}, 32'd2);
        res_ready = 1'b1;
        step();
        chk("bp_valid_drop", {31'd0, res_valid}, 32'd0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_overrun", {31'd0, overrun}, 32'd0);
        res_ready = 1'b0;
        exp_q.push_back(24'd3);
        beat(3'b001, 8'd3, 8'd0, 8'd0);
        res_ready = 1'b1;
        exp_q.push_back(24'd4);
        beat(3'b001, 8'd4, 8'd0, 8'd0);
        chk("acc_cmp_valid", {31'd0, res_valid}, 32'd1);
        chk("acc_cmp_overrun", {31'd0, overrun}, 32'd0);
        step();

        // clear mid-tile with a pending result
        res_ready = 1'b0;
        exp_q.push_back(24'd5);
        beat(3'b001, 8'd5, 8'd0, 8'd0);
        k_len = 8'd4;
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        chk("clr_busy_before", {31'd0, busy}, 32'd1);
        clear = 1'b1;
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        clear = 1'b0;
        chk("clr_busy_after", {31'd0, busy}, 32'd0);
        chk("clr_pending_valid", {31'd0, res_valid}, 32'd1);
        chk("clr_pending_data", {8'd0, res_data}, 32'd5);
        res_ready = 1'b1;
        exp_q.push_back(24'd4);
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        k_len = 8'd7;
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        chk("clr_tile_done", {30'd0, res_valid, busy}, 32'd2);
        step();

        // Reset mid-tile, then k_len=0 behaves as 1
        k_len = 8'd4;
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        beat(3'b001, 8'd1, 8'd0, 8'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        a_valid = 3'b111;
        a_in = {8'h33, 8'h22, 8'h11};
        step();
        chk("rst_mid_a_out", {8'd0, a_out}, 32'd0);
        chk("rst_mid_misc", {21'd0, w_q, a_valid_out}, 32'd0);
        chk("rst_mid_flags", {28'd0, res_valid, busy, overrun, sat_hit}, 32'd0);
        chk("rst_mid_data", {8'd0, res_data}, 32'd0);
        rst = 1'b0;
        a_valid = 3'b000;
        load_w(8'd7);
        k_len = 8'd0;
        exp_q.push_back(24'd42);
        beat(3'b001, 8'd6, 8'd0, 8'd0);
        chk("k0_done", {30'd0, res_valid, busy}, 32'd2);
        step();
        step();

        chk("main_queue_empty", exp_q.size(), 32'd0);
        chk("sat16_queue_empty", exps_q.size(), 32'd0);
        chk("wrap16_queue_empty", expw_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sys_mac_pe.md
Name: sys_mac_pe

Overview:
Weight-stationary multiply-accumulate processing element for the systolic array. Generalises the fixed three-channel PE to NCH input channels, with the following additions:
- a held weight register;
- optional saturating accumulation;
- a programmable tile length K;
- a double-buffered result register with valid/ready drain, so the array never stalls.

Activations and their valids pass to the neighbouring PE with one cycle of delay.

Parameters:
W, 8, signed activation/weight width
ACC_W, 24, signed accumulator/result width (ACC_W >= 2*W)
NCH, 3, number of activation input channels
SAT, 1, 1 = saturating add, 0 = two's-complement wrap
CNT_W, 8, width of tile-length counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  abort current tile, zero accumulator/counter/sticky flags
w_load  in  1  capture w_in into weight register
w_in  in  W  signed weight
w_q  out  W  current held weight
a_in  in  NCH*W  packed signed activations, channel i at [i*W +: W]
a_valid  in  NCH  per-channel valid
a_out  out  NCH*W  registered copy of a_in
a_valid_out  out  NCH  registered copy of a_valid
k_len  in  CNT_W  accumulations per tile, sampled at first beat of tile
res_data  out  ACC_W  completed tile result
res_valid  out  1  result pending
res_ready  in  1  downstream accepts result
busy  out  1  tile in progress (state ACC)
overrun  out  1  sticky: result overwritten before acceptance
sat_hit  out  1  sticky: saturation occurred (always 0 when SAT=0)

Behaviour:
- Reset values:
  - All outputs are 0.
  - w_q, accumulator, counter, k_len_q and state (IDLE) are cleared.
- Pass-through: every cycle a_out <= a_in and a_valid_out <= a_valid, including during clear. Only rst zeros them.
- Weight:
  - When w_load, w_q <= w_in.
  - A beat in the same cycle uses the old w_q.
- Beat selection:
  - A beat occurs when any a_valid bit is 1.
  - The lowest-index valid channel is used; other channels are ignored for accumulation but still passed through.
- Arithmetic:
  - The product a_sel*w_q is a signed 2W result, sign-extended to ACC_W.
  - The sum is computed at ACC_W+1 bits.
  - SAT=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set sat_hit if clamped.
  - SAT=0: truncate.
- FSM states:
  - IDLE (count=0): a beat samples k_len_q <= (k_len==0 ? 1 : k_len). It also accumulates.
    - If k_len_q is effectively 1, the beat completes the tile and the FSM stays in IDLE.
    - Otherwise the FSM goes to ACC with count=1.
  - ACC: each beat accumulates and increments count. The beat with count+1 == k_len_q completes the tile, returning to IDLE with count=0.
  - Cycles with no beat hold state.
- Completion, in the same clock as the final beat:
  - res_data <= final saturated/wrapped sum;
  - res_valid <= 1;
  - accumulator <= 0.
  - Latency: the result is visible the cycle after the last beat.
- Drain:
  - res_valid && res_ready with no completion → res_valid <= 0.
  - Completion in the same cycle as acceptance → new data loaded, res_valid stays 1, no overrun.
  - Completion while res_valid && !res_ready → data overwritten, overrun <= 1.
- clear (priority over beats):
  - Accumulator, counter, state→IDLE, overrun and sat_hit are all zeroed.
  - A beat in the same cycle is dropped.
  - res_data/res_valid are untouched, so a pending result stays deliverable.
  - w_q is untouched.
- rst has priority over clear and everything else. A mid-tile reset discards the partial sum and any pending result.
- k_len changes mid-tile are ignored until the next tile.
- busy = (state == ACC).

Test Plan:
- Basic dot product, W=8, ACC_W=24, NCH=3:
  - Stimulus: w_load 3; k_len=4; ch0 beats 1,2,3,4 on consecutive cycles; res_ready=1.
  - Response: res_valid one cycle after 4th beat, res_data=30, busy high for 3 cycles, then res_valid drops.
- Channel priority and pass-through:
  - Stimulus: w=2, k_len=2; beat1 valid={ch1=5, ch2=7}, beat2 valid={ch0=-4, ch2=9}.
  - Response: res_data=2 (10 - 8). a_out/a_valid_out equal the inputs delayed 1 cycle.
- Saturation, ACC_W=16, SAT=1:
  - Stimulus: w=127, k_len=3, a=127 ×3.
  - Response: res_data=32767, sat_hit=1. With SAT=0 the result wraps to -17149 and sat_hit=0.
- Backpressure/overrun:
  - Stimulus: k_len=1, res_ready=0, beats a=1 then a=2 (w=1).
  - Response: res_data=2, overrun=1. Raise res_ready → res_valid falls next cycle. Simultaneous accept+complete keeps res_valid=1, overrun=0.
- clear mid-tile:
  - Stimulus: k_len=4, 2 beats, then clear coinciding with a beat, then 4 fresh beats a=1, w=1.
  - Response: res_data=4, the dropped beat is not counted, a prior pending result is still delivered.
- Reset mid-tile and k_len=0:
  - Stimulus: rst during ACC.
  - Response: all outputs 0, FSM IDLE. Afterwards, k_len=0 with a single beat a=6, w=7 gives res_data=42 after 1 beat.
